// File: rtl/hexbus_pkg.sv
// Shared hexbus return-path definitions: nibble-code flags, idle word and code type.
package hexbus_pkg;

    localparam logic HB_NIB_HDR_FLAG = 1'b1;
    localparam logic HB_NIB_DAT_FLAG = 1'b0;

    localparam logic [33:0] HB_IDLE_WORD = 34'h3_6000_0000;

    typedef logic [4:0] hb_nib_t;

    function automatic hb_nib_t hb_hdr_code(input logic [1:0] cmd);
        return {HB_NIB_HDR_FLAG, 2'b00, cmd};
    endfunction

    function automatic hb_nib_t hb_dat_code(input logic [3:0] hex);
        return {HB_NIB_DAT_FLAG, hex};
    endfunction

endpackage

// File: rtl/hbnib_lzc.sv
// Leading-zero-nibble counter; result capped at NN-1 so at least one data nibble survives.
module hbnib_lzc #(
    parameter int unsigned DW = 32,
    parameter int unsigned CW = 4
) (
    input  logic [DW-1:0] data_i,
    output logic [CW-1:0] lz_c_o
);

    localparam int unsigned NN = DW / 4;

    logic [CW-1:0] lz;
    logic          found;

    // Only the top NN-1 nibbles are inspected, which gives the cap for free.
    always_comb begin
        lz    = '0;
        found = 1'b0;
        for (int i = int'(NN) - 1; i >= 1; i--) begin
            if (!found && data_i[4*i +: 4] == 4'h0) begin
                lz = lz + CW'(1);
            end else begin
                found = 1'b1;
            end
        end
    end

    assign lz_c_o = lz;

endmodule

// File: rtl/hbnibbler.sv
// Hexbus word-to-nibble serialiser: one header code then data codes, MS nibble first.
// Optional leading-zero suppression via HBNIBBLER_ZERO_SUPPRESS_EN.
module hbnibbler
    import hexbus_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_stb,
    input  logic [DW+1:0] i_word,
    output logic          o_busy,
    output logic          o_nib_stb,
    output logic [4:0]    o_nib,
    input  logic          i_nib_busy
);

    localparam int unsigned NN = DW / 4;
    localparam int unsigned CW = $clog2(NN + 1);

    logic [DW-1:0] sreg_q, sreg_d;
    logic [CW-1:0] count_q, count_d;
    logic          nib_stb_q, nib_stb_d;
    hb_nib_t       nib_q, nib_d;

    logic          accept;
    logic [DW-1:0] load_sreg;
    logic [CW-1:0] load_count;

`ifdef HBNIBBLER_ZERO_SUPPRESS_EN
    logic [CW-1:0] lz;

    hbnib_lzc #(
        .DW (DW),
        .CW (CW)
    ) u_lzc (
        .data_i (i_word[DW-1:0]),
        .lz_c_o (lz)
    );

    assign load_count = CW'(NN) - lz;
    assign load_sreg  = i_word[DW-1:0] << {lz, 2'b00};
`else
    assign load_count = CW'(NN);
    assign load_sreg  = i_word[DW-1:0];
`endif

    assign o_busy = nib_stb_q && (i_nib_busy || count_q != '0);
    assign accept = i_stb && !o_busy;

    // Advance and accept are mutually exclusive: advancing implies o_busy.
    always_comb begin
        sreg_d    = sreg_q;
        count_d   = count_q;
        nib_stb_d = nib_stb_q;
        nib_d     = nib_q;
        if (nib_stb_q && !i_nib_busy && count_q != '0) begin
            nib_d   = hb_dat_code(sreg_q[DW-1 -: 4]);
            sreg_d  = sreg_q << 4;
            count_d = count_q - CW'(1);
        end else if (accept) begin
            nib_stb_d = 1'b1;
            nib_d     = hb_hdr_code(i_word[DW+1:DW]);
            sreg_d    = load_sreg;
            count_d   = load_count;
        end else if (nib_stb_q && !i_nib_busy) begin
            nib_stb_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sreg_q    <= '0;
            count_q   <= '0;
            nib_stb_q <= 1'b0;
            nib_q     <= '0;
        end else begin
            sreg_q    <= sreg_d;
            count_q   <= count_d;
            nib_stb_q <= nib_stb_d;
            nib_q     <= nib_d;
        end
    end

    assign o_nib_stb = nib_stb_q;
    assign o_nib     = nib_q;

endmodule

// File: tb/tb_hbnibbler.sv
// Self-checking bench for hbnibbler: directed vector table, multi-cycle corner cases, random vs queue model.
module tb_hbnibbler;
    import hexbus_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned NN = DW / 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_stb;
    logic [DW+1:0] i_word;
    logic          o_busy;
    logic          o_nib_stb;
    logic [4:0]    o_nib;
    logic          i_nib_busy;

    int total = 0;
    int bad   = 0;

    hbnibbler #(.DW(DW)) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_stb      (i_stb),
        .i_word     (i_word),
        .o_busy     (o_busy),
        .o_nib_stb  (o_nib_stb),
        .o_nib      (o_nib),
        .i_nib_busy (i_nib_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [33:0]       word;
        int                n;
        logic [8:0][4:0]   codes;   // first code in [8]
    } vec_t;

    vec_t vecs[5];
    logic [4:0] mq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: header, then significant nibbles (all NN unless suppression is built in).
    task automatic push_word(input logic [33:0] w);
        logic [31:0] d;
        int nsig;
        d = w[31:0];
        nsig = NN;
`ifdef HBNIBBLER_ZERO_SUPPRESS_EN
        nsig = 1;
        while (nsig < int'(NN) && (d >> (4 * nsig)) != 0) nsig++;
`endif
        mq.push_back({1'b1, 2'b00, w[33:32]});
        for (int i = nsig - 1; i >= 0; i--) mq.push_back({1'b0, 4'((d >> (4 * i)) & 32'hF)});
    endtask

    task automatic send_and_check(input vec_t v, input string nm);
        int guard;
        guard = 0;
        @(negedge clk); i_stb = 1'b1; i_word = v.word; #1;
        while (o_busy && guard < 50) begin @(negedge clk); #1; guard++; end
        chk({nm, "_accept_timeout"}, 32'(guard >= 50), 32'd0);
        @(negedge clk); i_stb = 1'b0; #1;
        for (int k = 0; k < v.n; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            chk($sformatf("%s_code%0d", nm, k), {26'd0, o_nib_stb, o_nib}, {26'd0, 1'b1, v.codes[8-k]});
        end
        @(negedge clk); #1;
        chk({nm, "_stb_drop"}, 32'(o_nib_stb), 32'd0);
    endtask

    initial begin
        vec_t cat;
        logic [4:0] exp_code;
        logic accepted;
        int guard;

        vecs[0] = '{34'h2_DEAD_BEEF, 9, {5'h12,5'h0D,5'h0E,5'h0A,5'h0D,5'h0B,5'h0E,5'h0E,5'h0F}};
        vecs[1] = '{HB_IDLE_WORD,    9, {5'h13,5'h06,5'h00,5'h00,5'h00,5'h00,5'h00,5'h00,5'h00}};
`ifdef HBNIBBLER_ZERO_SUPPRESS_EN
        vecs[2] = '{34'h1_0000_00A5, 3, {5'h11,5'h0A,5'h05,30'h0}};
        vecs[3] = '{34'h0_0000_0000, 2, {5'h10,5'h00,35'h0}};
        vecs[4] = '{34'h3_0F00_0000, 8, {5'h13,5'h0F,5'h00,5'h00,5'h00,5'h00,5'h00,5'h00,5'h00}};
`else
        vecs[2] = '{34'h1_0000_00A5, 9, {5'h11,5'h00,5'h00,5'h00,5'h00,5'h00,5'h00,5'h0A,5'h05}};
        vecs[3] = '{34'h0_0000_0000, 9, {5'h10,5'h00,5'h00,5'h00,5'h00,5'h00,5'h00,5'h00,5'h00}};
        vecs[4] = '{34'h3_0F00_0000, 9, {5'h13,5'h00,5'h0F,5'h00,5'h00,5'h00,5'h00,5'h00,5'h00}};
`endif

        rst = 1'b1; i_stb = 1'b0; i_word = '0; i_nib_busy = 1'b0;
        #12;
        chk("reset_stb",  32'(o_nib_stb), 32'd0);
        chk("reset_nib",  32'(o_nib),     32'd0);
        chk("reset_busy", 32'(o_busy),    32'd0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 5; i++) send_and_check(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back: second header immediately follows the first word's last data code.
        cat.word = '0; cat.n = 0; cat.codes = '0;
        @(negedge clk); i_stb = 1'b1; i_word = vecs[0].word; #1;
        chk("b2b_idle_busy", 32'(o_busy), 32'd0);
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            if (k == 1) i_word = HB_IDLE_WORD;
            if (k == 9) i_stb = 1'b0;
            #1;
            exp_code = (k < 9) ? vecs[0].codes[8-k] : vecs[1].codes[17-k];
            chk($sformatf("b2b_code%0d", k), {26'd0, o_nib_stb, o_nib}, {26'd0, 1'b1, exp_code});
        end
        @(negedge clk); #1;
        chk("b2b_stb_drop", 32'(o_nib_stb), 32'd0);

        // Downstream stall of 3 cycles while the 4th code is shown.
        @(negedge clk); i_stb = 1'b1; i_word = vecs[0].word; #1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            i_stb = 1'b0;
            i_nib_busy = (k >= 3 && k <= 5);
            #1;
            exp_code = vecs[0].codes[8 - ((k <= 3) ? k : (k <= 6 ? 3 : k - 3))];
            chk($sformatf("stall_code%0d", k), {26'd0, o_nib_stb, o_nib}, {26'd0, 1'b1, exp_code});
            if (k >= 3 && k <= 5) chk($sformatf("stall_busy%0d", k), 32'(o_busy), 32'd1);
        end
        i_nib_busy = 1'b0;
        @(negedge clk); #1;
        chk("stall_stb_drop", 32'(o_nib_stb), 32'd0);

        // Reset while the 4th code is displayed; next word must come out whole.
        @(negedge clk); i_stb = 1'b1; i_word = vecs[1].word; #1;
        for (int k = 0; k < 4; k++) begin @(negedge clk); i_stb = 1'b0; end
        rst = 1'b1; #1;
        chk("midrst_stb",  32'(o_nib_stb), 32'd0);
        chk("midrst_nib",  32'(o_nib),     32'd0);
        chk("midrst_busy", 32'(o_busy),    32'd0);
        @(negedge clk); rst = 1'b0; #1;
        chk("midrst_quiet", 32'(o_nib_stb), 32'd0);
        send_and_check(vecs[0], "after_rst");

        // Random traffic against the queue model.
        accepted = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!(i_stb && !accepted)) begin
                i_stb  = ($urandom_range(0, 3) != 0);
                i_word = {2'($urandom_range(0, 3)), 32'($urandom) >> (4 * $urandom_range(0, 8))};
            end
            i_nib_busy = ($urandom_range(0, 3) == 0);
            #1;
            chk("rnd_stb", 32'(o_nib_stb), 32'(mq.size() != 0));
            chk("rnd_busy", 32'(o_busy), 32'(mq.size() != 0 && (i_nib_busy || mq.size() > 1)));
            if (o_nib_stb && !i_nib_busy) begin
                if (mq.size() == 0) chk("rnd_unexpected_code", 32'(o_nib), 32'h100);
                else chk("rnd_code", 32'(o_nib), 32'(mq.pop_front()));
            end
            accepted = i_stb && !o_busy;
            if (accepted) push_word(i_word);
        end
        @(negedge clk); i_stb = 1'b0; i_nib_busy = 1'b0;
        guard = 0;
        #1;
        while (mq.size() != 0 && guard < 50) begin
            if (o_nib_stb) chk("drain_code", 32'(o_nib), 32'(mq.pop_front()));
            else begin chk("drain_stb", 32'(o_nib_stb), 32'd1); void'(mq.pop_front()); end
            @(negedge clk); #1; guard++;
        end
        chk("drain_timeout", 32'(guard >= 50), 32'd0);
        chk("drain_idle", 32'(o_nib_stb), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
